alarm_trigger: RTL and testbench

//  Produces the ring1/ring2 start pulses consumed by the tone/speaker block.

---
 rtl/alarm_pkg.sv | 26 ++
 rtl/alarm_trigger_if.sv | 23 ++
 rtl/alarm_slot.sv | 109 ++++++++++
 rtl/alarm_trigger.sv | 98 +++++++++
 tb/tb_alarm_trigger.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types, field widths/limits and snooze time arithmetic for alarm_trigger.
package alarm_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, FIRED, SNOOZE} slot_state_t;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    // Adds d minutes (1..59) to h:m, carrying into the hour and wrapping 23 -> 00.
    function automatic logic [HOUR_W+MIN_W-1:0] add_min(
        input logic [HOUR_W-1:0] h,
        input logic [MIN_W-1:0]  m,
        input int unsigned       d
    );
        logic [MIN_W:0]    s;
        logic [HOUR_W-1:0] h2;
        logic [MIN_W-1:0]  m2;
        s  = {1'b0, m} + (MIN_W+1)'(d);
        m2 = (s > {1'b0, MIN_MAX}) ? MIN_W'(s - 7'd60) : s[MIN_W-1:0];
        h2 = (s > {1'b0, MIN_MAX}) ? ((h == HOUR_MAX) ? '0 : h + HOUR_W'(1)) : h;
        return {h2, m2};
    endfunction

endpackage

// File: rtl/alarm_trigger_if.sv
// alarm_trigger_if: slot configuration write bus with its ack/err response.
interface alarm_trigger_if;
    import alarm_pkg::*;

    logic              cfg_wr;
    logic              cfg_sel;
    logic [HOUR_W-1:0] cfg_hour;
    logic [MIN_W-1:0]  cfg_min;
    logic              cfg_en;
    logic              cfg_ack;
    logic              cfg_err;

    modport master (
        output cfg_wr, cfg_sel, cfg_hour, cfg_min, cfg_en,
        input  cfg_ack, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_sel, cfg_hour, cfg_min, cfg_en,
        output cfg_ack, cfg_err
    );

endinterface

// File: rtl/alarm_slot.sv
// alarm_slot: one alarm slot FSM with stored hh:mm and match compare.
// Snooze state and target registers exist only when ALARM_SNOOZE_EN is defined.
module alarm_slot
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strobe,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [MIN_W-1:0]  cur_sec,
    input  logic              load,
    input  logic [HOUR_W-1:0] cfg_hour,
    input  logic [MIN_W-1:0]  cfg_min,
    input  logic              cfg_en,
    input  logic              stop,
    input  logic              snooze,
    output logic              fire,
    output logic              active
);

    slot_state_t       state_q, state_d;
    logic [HOUR_W-1:0] hh_q, hh_d;
    logic [MIN_W-1:0]  mm_q, mm_d;
    logic [MIN_W-1:0]  lock_m;
    logic              tick0;

    assign tick0  = strobe && (cur_sec == '0);
    assign active = (state_q == FIRED) || (state_q == SNOOZE);

`ifdef ALARM_SNOOZE_EN
    // th/tm hold the most recent fire time; a snooze advances it to the re-fire time.
    logic [HOUR_W-1:0] th_q, th_d;
    logic [MIN_W-1:0]  tm_q, tm_d;
    assign lock_m = tm_q;
`else
    logic unused_snz;
    assign lock_m     = mm_q;
    assign unused_snz = snooze | (SNOOZE_MIN == 0);
`endif

    always_comb begin
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        fire    = 1'b0;
`ifdef ALARM_SNOOZE_EN
        th_d    = th_q;
        tm_d    = tm_q;
`endif
        if (load) begin
            hh_d    = cfg_hour;
            mm_d    = cfg_min;
            state_d = cfg_en ? ARMED : IDLE;
        end else if (stop) begin
            state_d = (state_q == FIRED || state_q == SNOOZE) ? ARMED : state_q;
        end else begin
            case (state_q)
                ARMED: if (tick0 && cur_hour == hh_q && cur_min == mm_q) begin
                    fire    = 1'b1;
                    state_d = FIRED;
`ifdef ALARM_SNOOZE_EN
                    th_d    = hh_q;
                    tm_d    = mm_q;
`endif
                end
                FIRED: begin
`ifdef ALARM_SNOOZE_EN
                    if (snooze) begin
                        state_d      = SNOOZE;
                        {th_d, tm_d} = add_min(th_q, tm_q, SNOOZE_MIN);
                    end else
`endif
                    if (strobe && cur_min != lock_m) state_d = ARMED;
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: if (tick0 && cur_hour == th_q && cur_min == tm_q) begin
                    fire    = 1'b1;
                    state_d = FIRED;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hh_q    <= '0;
            mm_q    <= '0;
`ifdef ALARM_SNOOZE_EN
            th_q    <= '0;
            tm_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
`ifdef ALARM_SNOOZE_EN
            th_q    <= th_d;
            tm_q    <= tm_d;
`endif
        end
    end

endmodule

// File: rtl/alarm_trigger.sv
// alarm_trigger: two alarm slots plus hourly chime producing registered ring1/ring2 start pulses.
// Optional snooze support is enabled by defining ALARM_SNOOZE_EN.
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_1hz_posedge,
    input  logic [HOUR_W-1:0]    cur_hour,
    input  logic [MIN_W-1:0]     cur_min,
    input  logic [MIN_W-1:0]     cur_sec,
    alarm_trigger_if.slave       cfg,
    input  logic                 chime_en,
    input  logic                 stop,
    input  logic                 snooze,
    output logic                 ring1,
    output logic                 ring2,
    output logic [1:0]           slot_active
);

    logic bad, load0, load1, fire0, fire1, chime, r2_evt;
    logic ack_q, ack_d, err_q, err_d;
    logic ring1_q, ring1_d, ring2_q, ring2_d, pend_q, pend_d;

    assign bad   = (cfg.cfg_hour > HOUR_MAX) || (cfg.cfg_min > MIN_MAX);
    assign load0 = cfg.cfg_wr && !bad && !cfg.cfg_sel;
    assign load1 = cfg.cfg_wr && !bad &&  cfg.cfg_sel;

    alarm_slot #(.SNOOZE_MIN(SNOOZE_MIN)) u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe   (clk_1hz_posedge),
        .cur_hour (cur_hour),
        .cur_min  (cur_min),
        .cur_sec  (cur_sec),
        .load     (load0),
        .cfg_hour (cfg.cfg_hour),
        .cfg_min  (cfg.cfg_min),
        .cfg_en   (cfg.cfg_en),
        .stop     (stop),
        .snooze   (snooze),
        .fire     (fire0),
        .active   (slot_active[0])
    );

    alarm_slot #(.SNOOZE_MIN(SNOOZE_MIN)) u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .strobe   (clk_1hz_posedge),
        .cur_hour (cur_hour),
        .cur_min  (cur_min),
        .cur_sec  (cur_sec),
        .load     (load1),
        .cfg_hour (cfg.cfg_hour),
        .cfg_min  (cfg.cfg_min),
        .cfg_en   (cfg.cfg_en),
        .stop     (stop),
        .snooze   (snooze),
        .fire     (fire1),
        .active   (slot_active[1])
    );

    assign chime  = clk_1hz_posedge && chime_en && (cur_min == '0) && (cur_sec == '0);
    assign r2_evt = fire1 || chime;

    // A ring2 event colliding with ring1 is deferred to the next strobe; slot-1 and chime merge.
    always_comb begin
        ack_d   = cfg.cfg_wr;
        err_d   = cfg.cfg_wr && bad;
        ring1_d = fire0;
        ring2_d = (r2_evt && !fire0) || (clk_1hz_posedge && pend_q && !stop);
        pend_d  = stop ? 1'b0 : (fire0 && r2_evt) ? 1'b1 : clk_1hz_posedge ? 1'b0 : pend_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            ring1_q <= 1'b0;
            ring2_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            err_q   <= err_d;
            ring1_q <= ring1_d;
            ring2_q <= ring2_d;
            pend_q  <= pend_d;
        end
    end

    assign cfg.cfg_ack = ack_q;
    assign cfg.cfg_err = err_q;
    assign ring1       = ring1_q;
    assign ring2       = ring2_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: directed self-checking bench for alarm_trigger (snooze steps follow ALARM_SNOOZE_EN).
module tb_alarm_trigger;
    import alarm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic strobe = 1'b0;
    logic [HOUR_W-1:0] cur_hour = '0;
    logic [MIN_W-1:0]  cur_min = '0, cur_sec = '0;
    logic chime_en = 1'b0, stop = 1'b0, snooze = 1'b0;
    logic ring1, ring2;
    logic [1:0] slot_active;
    int checks = 0, failures = 0;
    int seen;

    alarm_trigger_if cfg_if ();

    alarm_trigger #(.SNOOZE_MIN(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_1hz_posedge (strobe),
        .cur_hour        (cur_hour),
        .cur_min         (cur_min),
        .cur_sec         (cur_sec),
        .cfg             (cfg_if),
        .chime_en        (chime_en),
        .stop            (stop),
        .snooze          (snooze),
        .ring1           (ring1),
        .ring2           (ring2),
        .slot_active     (slot_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_strobe(input int h, input int m, input int s);
        cur_hour = HOUR_W'(h);
        cur_min  = MIN_W'(m);
        cur_sec  = MIN_W'(s);
        strobe   = 1'b1;
        tick();
        strobe   = 1'b0;
    endtask

    task automatic cfg_write(input logic sel, input int h, input int m, input logic en, input logic exp_err);
        cfg_if.cfg_wr   = 1'b1;
        cfg_if.cfg_sel  = sel;
        cfg_if.cfg_hour = HOUR_W'(h);
        cfg_if.cfg_min  = MIN_W'(m);
        cfg_if.cfg_en   = en;
        tick();
        cfg_if.cfg_wr   = 1'b0;
        chk("cfg_ack", {7'd0, cfg_if.cfg_ack}, 8'd1);
        chk("cfg_err", {7'd0, cfg_if.cfg_err}, {7'd0, exp_err});
    endtask

    initial begin
        cfg_if.cfg_wr = 1'b0;
        cfg_if.cfg_sel = 1'b0;
        cfg_if.cfg_hour = '0;
        cfg_if.cfg_min = '0;
        cfg_if.cfg_en = 1'b0;
        tick();
        tick();
        chk("rst_ring1", {7'd0, ring1}, 8'd0);
        chk("rst_ring2", {7'd0, ring2}, 8'd0);
        chk("rst_ack", {7'd0, cfg_if.cfg_ack}, 8'd0);
        chk("rst_active", {6'd0, slot_active}, 8'd0);
        rst_n = 1'b1;
        tick();
        // Reset contents are 00:00 IDLE: a midnight strobe must not ring.
        pulse_strobe(0, 0, 0);
        chk("idle_no_ring", {6'd0, ring2, ring1}, 8'd0);

        // 1: basic fire, one-clock pulse
        cfg_write(1'b0, 7, 30, 1'b1, 1'b0);
        tick();
        chk("ack_drop", {7'd0, cfg_if.cfg_ack}, 8'd0);
        pulse_strobe(7, 30, 0);
        chk("t1_ring1", {7'd0, ring1}, 8'd1);
        chk("t1_ring2", {7'd0, ring2}, 8'd0);
        chk("t1_active", {6'd0, slot_active}, 8'd1);
        tick();
        chk("t1_ring1_width", {7'd0, ring1}, 8'd0);

        // 2: lockout within the minute, then return to ARMED
        seen = 0;
        for (int s = 1; s < 60; s++) begin
            pulse_strobe(7, 30, s);
            seen += int'(ring1);
        end
        chk("t2_no_refire", 8'(seen), 8'd0);
        chk("t2_still_fired", {6'd0, slot_active}, 8'd1);
        pulse_strobe(7, 31, 0);
        chk("t2_rearmed", {6'd0, slot_active}, 8'd0);
        chk("t2_ring1", {7'd0, ring1}, 8'd0);

        // 3: simultaneous slot0, slot1 and chime -> ring1 now, single deferred ring2
        cfg_write(1'b0, 12, 0, 1'b1, 1'b0);
        cfg_write(1'b1, 12, 0, 1'b1, 1'b0);
        chime_en = 1'b1;
        pulse_strobe(12, 0, 0);
        chk("t3_ring1", {7'd0, ring1}, 8'd1);
        chk("t3_ring2_deferred", {7'd0, ring2}, 8'd0);
        chk("t3_active", {6'd0, slot_active}, 8'd3);
        tick();
        tick();
        tick();
        chk("t3_ring2_waits", {6'd0, ring2, ring1}, 8'd0);
        pulse_strobe(12, 0, 1);
        chk("t3_ring2_pending", {6'd0, ring2, ring1}, 8'd2);
        tick();
        chk("t3_ring2_width", {7'd0, ring2}, 8'd0);
        pulse_strobe(12, 0, 2);
        chk("t3_single_ring2", {7'd0, ring2}, 8'd0);
        pulse_strobe(12, 1, 0);
        chk("t3_rearmed", {6'd0, slot_active}, 8'd0);
        pulse_strobe(13, 0, 0);
        chk("chime_only", {6'd0, ring2, ring1}, 8'd2);
        chime_en = 1'b0;

        // 4: rejected writes leave slot 0 at 12:00
        cfg_write(1'b0, 24, 0, 1'b1, 1'b1);
        cfg_write(1'b0, 0, 60, 1'b1, 1'b1);
        pulse_strobe(0, 0, 0);
        chk("t4_no_ring", {6'd0, ring2, ring1}, 8'd0);
        chk("t4_active", {6'd0, slot_active}, 8'd0);
        pulse_strobe(12, 0, 0);
        chk("t4_kept_1200", {6'd0, ring2, ring1}, 8'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_active", {6'd0, slot_active}, 8'd0);
        pulse_strobe(12, 0, 1);
        chk("stop_clears_pend", {6'd0, ring2, ring1}, 8'd0);
        cfg_write(1'b0, 12, 0, 1'b0, 1'b0);

        // 5: slot1 at 23:58, snooze wrapping past midnight
        cfg_write(1'b1, 23, 58, 1'b1, 1'b0);
        pulse_strobe(23, 58, 0);
        chk("t5_ring2", {6'd0, ring2, ring1}, 8'd2);
        chk("t5_active", {6'd0, slot_active}, 8'd2);
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        pulse_strobe(23, 59, 0);
`ifdef ALARM_SNOOZE_EN
        chk("t5_snoozed", {6'd0, slot_active}, 8'd2);
        chk("t5_quiet", {7'd0, ring2}, 8'd0);
        pulse_strobe(0, 3, 0);
        chk("t5_refire", {7'd0, ring2}, 8'd1);
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_stopped", {6'd0, slot_active}, 8'd0);
        pulse_strobe(0, 8, 0);
        chk("t5_no_refire", {7'd0, ring2}, 8'd0);
`else
        chk("t5_snooze_ignored", {6'd0, slot_active}, 8'd0);
        pulse_strobe(0, 3, 0);
        chk("t5_no_snooze_ring", {7'd0, ring2}, 8'd0);
`endif

        // 6: asynchronous reset during FIRED
        cfg_write(1'b0, 6, 0, 1'b1, 1'b0);
        pulse_strobe(6, 0, 0);
        chk("t6_ring1", {7'd0, ring1}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_rst", {5'd0, ring2, ring1, cfg_if.cfg_ack}, 8'd0);
        chk("t6_rst_active", {6'd0, slot_active}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_release", {6'd0, ring2, ring1}, 8'd0);
        pulse_strobe(6, 0, 0);
        chk("t6_cleared", {6'd0, ring2, ring1}, 8'd0);
        pulse_strobe(23, 58, 0);
        chk("t6_slot1_cleared", {6'd0, ring2, ring1}, 8'd0);
        cfg_write(1'b0, 6, 0, 1'b1, 1'b0);
        pulse_strobe(6, 0, 0);
        chk("t6_reprogram", {6'd0, ring2, ring1}, 8'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
